// File: rtl/hex_ascii_pkg.sv
// Shared types and helpers for the hex-to-ASCII character streamer.
package hex_ascii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PFX0,
    PFXX,
    DIGIT,
    TERM_CR,
    TERM_LF
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_X       = 8'h78;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  // 0-9 map onto '0'..'9'; 10-15 onto 'A'..'F' or 'a'..'f'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                 input logic       lowercase);
    if (nibble < 4'd10)
      return ASCII_ZERO + {4'h0, nibble};
    return (lowercase ? ASCII_LOWER_A : ASCII_UPPER_A) + {4'h0, nibble} - 8'd10;
  endfunction

endpackage

// File: rtl/hex_digit_encoder.sv
// Combinational single-nibble to ASCII converter.
module hex_digit_encoder
  import hex_ascii_pkg::*;
#(
  parameter bit LOWERCASE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = nibble_to_ascii(nibble, LOWERCASE);

endmodule

// File: rtl/hex_ascii_streamer.sv
// Streams a captured hex value as ASCII characters over a valid/ready link,
// with optional "0x" prefix, CR/LF terminator and leading-zero suppression.
// All outputs are registered; the next character is computed from the next
// state so a new character follows every handshake without a bubble.
module hex_ascii_streamer
  import hex_ascii_pkg::*;
#(
  parameter int NIBBLES   = 4,
  parameter bit PREFIX_EN = 1'b1,
  parameter bit TERM_EN   = 1'b1,
  parameter bit LOWERCASE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4*NIBBLES-1:0] value_in,
  input  logic                 start,
  input  logic                 suppress_zeros,
  output logic                 in_ready,
  output logic [7:0]           char_out,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic                 done
);

  localparam int              IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_MSN = IDX_W'(NIBBLES - 1);

  state_t                    state_q, state_d;
  logic [NIBBLES-1:0][3:0]   val_q, val_d;
  logic [IDX_W-1:0]          idx_q, idx_d, lead_idx;
  logic [7:0]                char_d, digit_char;
  logic                      done_d;
  logic                      hs;

  assign hs       = char_valid && char_ready;
  assign in_ready = (state_q == IDLE);

  // Leading-zero priority encoder: highest non-zero nibble wins, all-zero gives 0.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < NIBBLES; i++)
      if (value_in[4*i +: 4] != 4'h0) lead_idx = IDX_W'(i);
  end

  // Next-state logic; every non-IDLE state holds until its character handshakes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d = value_in;
          idx_d = suppress_zeros ? lead_idx : IDX_MSN;
          if (PREFIX_EN) state_d = PFX0;
          else           state_d = DIGIT;
        end
      end
      PFX0:    if (hs) state_d = PFXX;
      PFXX:    if (hs) state_d = DIGIT;
      DIGIT: begin
        if (hs) begin
          if (idx_q == '0) begin
            if (TERM_EN) state_d = TERM_CR;
            else         state_d = IDLE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      TERM_CR: if (hs) state_d = TERM_LF;
      TERM_LF: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Encode the nibble that will be on display next cycle.
  hex_digit_encoder #(.LOWERCASE(LOWERCASE)) u_enc (
    .nibble (val_d[idx_d]),
    .ascii  (digit_char)
  );

  // Character selected by the upcoming state; IDLE drives zero.
  always_comb begin
    char_d = 8'h00;
    case (state_d)
      PFX0:    char_d = ASCII_ZERO;
      PFXX:    char_d = ASCII_X;
      DIGIT:   char_d = digit_char;
      TERM_CR: char_d = ASCII_CR;
      TERM_LF: char_d = ASCII_LF;
      default: char_d = 8'h00;
    endcase
    done_d = hs && (state_d == IDLE);
  end

  // FSM, captured value and digit index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
    end
  end

  // Registered output stage: character, valid and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      char_out   <= char_d;
      char_valid <= (state_d != IDLE);
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Self-checking bench: two streamer configurations driven by directed and
// randomized messages, compared against a string-based message model.
module tb_hex_ascii_streamer;

  typedef logic [7:0] ch_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value_in = '0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        suppress = 1'b0;
  logic        char_ready = 1'b0;

  logic        ir1, cv1, dn1, ir2, cv2, dn2;
  ch_t         co1, co2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Default configuration: prefix + terminator, uppercase.
  hex_ascii_streamer #(.NIBBLES(4), .PREFIX_EN(1'b1), .TERM_EN(1'b1), .LOWERCASE(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .start(start1),
    .suppress_zeros(suppress), .in_ready(ir1), .char_out(co1), .char_valid(cv1),
    .char_ready(char_ready), .done(dn1)
  );

  // Bare lowercase digits only.
  hex_ascii_streamer #(.NIBBLES(4), .PREFIX_EN(1'b0), .TERM_EN(1'b0), .LOWERCASE(1'b1)) u_dut_lc (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .start(start2),
    .suppress_zeros(suppress), .in_ready(ir2), .char_out(co2), .char_valid(cv2),
    .char_ready(char_ready), .done(dn2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Message model: the text a human would write for the value.
  function automatic void model(input logic [15:0] v, input bit sup, input int which,
                                output ch_t q[$]);
    string hx;
    int    first;
    int    d;
    hx = (which == 2) ? "0123456789abcdef" : "0123456789ABCDEF";
    q.delete();
    if (which == 1) begin q.push_back(8'h30); q.push_back(8'h78); end
    first = 3;
    if (sup) begin
      first = 0;
      for (int i = 3; i >= 0; i--)
        if (((v >> (4*i)) & 16'hF) != 0) begin first = i; break; end
    end
    for (int i = first; i >= 0; i--) begin
      d = int'((v >> (4*i)) & 16'hF);
      q.push_back(ch_t'(hx[d]));
    end
    if (which == 1) begin q.push_back(8'h0D); q.push_back(8'h0A); end
  endfunction

  // Drives one message and records handshaken characters (no checking here).
  // mode: 0 always ready, 1 ready pattern 1,0,0..., 2 random ready.
  task automatic stream(input int which, input logic [15:0] v, input bit sup,
                        input int mode, input int mid_k, input bit hold,
                        output ch_t got[$], output int cyc, output int ir_low,
                        output int stalls_bad, output bit to);
    bit  pv, pr, cr;
    ch_t pc, oc;
    logic ov, od, oir;
    got.delete();
    cyc = 0; ir_low = 0; stalls_bad = 0; to = 1'b1;
    pv = 1'b0; pr = 1'b0; pc = '0;
    @(negedge clk);
    value_in = v; suppress = sup; char_ready = 1'b1;
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!hold) begin
        start1 = 1'b0; start2 = 1'b0;
        value_in = 16'($urandom);
        suppress = 1'($urandom_range(0, 1));
      end
      if (k == mid_k) begin
        value_in = 16'hFFFF;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
      end
      cr = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      char_ready = cr;
      ov  = (which == 1) ? cv1 : cv2;
      oc  = (which == 1) ? co1 : co2;
      od  = (which == 1) ? dn1 : dn2;
      oir = (which == 1) ? ir1 : ir2;
      if (!oir) ir_low++;
      if (pv && !pr && (!ov || oc != pc)) stalls_bad++;
      if (od) begin cyc = k + 1; to = 1'b0; break; end
      if (ov && cr) got.push_back(oc);
      pv = ov; pr = cr; pc = oc;
    end
    char_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ir1 !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", ir1); end
    checks++; if (cv1 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", cv1); end
    checks++; if (co1 !== 8'h00) begin failures++; $display("FAIL rst_char got=%h exp=00", co1); end
    checks++; if (dn1 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", dn1); end
    checks++; if ({ir2, cv2, dn2, co2} !== {1'b1, 1'b0, 1'b0, 8'h00})
      begin failures++; $display("FAIL rst_lc got=%b%b%b/%h exp=100/00", ir2, cv2, dn2, co2); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    ch_t got[$]; ch_t exp[$];
    int cyc, irl, sb; bit to;
    exp = '{8'h30, 8'h78, 8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
    stream(1, 16'h1A3F, 1'b0, 0, -1, 1'b0, got, cyc, irl, sb, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
    checks++; if (cyc != 9) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=9", cyc); end
    checks++; if (irl != 8) begin failures++; $display("FAIL basic_in_ready_low got=%0d exp=8", irl); end
    checks++;
    if (got.size() != exp.size()) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL basic_char[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_suppress();
    logic [15:0] vals[4] = '{16'h00B0, 16'h00B0, 16'h0000, 16'h0000};
    bit          sups[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int          lens[4] = '{6, 8, 5, 8};
    ch_t got[$]; ch_t exp[$];
    int cyc, irl, sb; bit to;
    for (int t = 0; t < 4; t++) begin
      model(vals[t], sups[t], 1, exp);
      stream(1, vals[t], sups[t], 0, -1, 1'b0, got, cyc, irl, sb, to);
      checks++; if (to || cyc != lens[t] + 1)
        begin failures++; $display("FAIL sup%0d_done_cycle got=%0d exp=%0d", t, cyc, lens[t] + 1); end
      checks++;
      if (got.size() != lens[t]) begin failures++; $display("FAIL sup%0d_len got=%0d exp=%0d", t, got.size(), lens[t]); end
      else foreach (exp[i]) begin
        checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL sup%0d_char[%0d] got=%h exp=%h", t, i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    ch_t got[$]; ch_t exp[$];
    int cyc, irl, sb; bit to;
    model(16'hC0DE, 1'b0, 1, exp);
    stream(1, 16'hC0DE, 1'b0, 1, 4, 1'b0, got, cyc, irl, sb, to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout got=timeout exp=done"); end
    checks++; if (sb != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", sb); end
    checks++;
    if (got.size() != exp.size()) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL bp_char[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    @(negedge clk);
    checks++; if (cv1 !== 1'b0 || ir1 !== 1'b1)
      begin failures++; $display("FAIL bp_midstart_ignored got=valid%b ready%b exp=valid0 ready1", cv1, ir1); end
  endtask

  task automatic test_back_to_back();
    ch_t got[$]; ch_t exp[$];
    int cyc, irl, sb; bit to, seen;
    exp = '{8'h61, 8'h62, 8'h63, 8'h64};
    stream(2, 16'hABCD, 1'b0, 0, -1, 1'b1, got, cyc, irl, sb, to);
    checks++; if (to || cyc != 5) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=5", cyc); end
    checks++;
    if (got.size() != exp.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL b2b_char[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    @(negedge clk);
    checks++; if (cv2 !== 1'b1 || co2 !== 8'h61 || dn2 !== 1'b0)
      begin failures++; $display("FAIL b2b_restart got=valid%b char%h done%b exp=valid1 char61 done0", cv2, co2, dn2); end
    start2 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (dn2) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL b2b_second_done got=timeout exp=done"); end
  endtask

  task automatic test_reset_mid();
    ch_t got[$]; ch_t exp[$];
    int cyc, irl, sb; bit to, sup, bad;
    @(negedge clk);
    value_in = 16'h1234; suppress = 1'b0; start1 = 1'b1; char_ready = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    checks++; if (cv1 !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", cv1); end
    reset_n = 1'b0;
    #1;
    checks++; if (cv1 !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", cv1); end
    checks++; if (co1 !== 8'h00) begin failures++; $display("FAIL rmid_char got=%h exp=00", co1); end
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (dn1 !== 1'b0 || cv1 !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin failures++; $display("FAIL rmid_no_done got=activity exp=quiet"); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (ir1 !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", ir1); end
    sup = 1'($urandom_range(0, 1));
    model(16'h0001, sup, 1, exp);
    stream(1, 16'h0001, sup, 2, -1, 1'b0, got, cyc, irl, sb, to);
    checks++; if (to) begin failures++; $display("FAIL rmid_timeout got=timeout exp=done"); end
    checks++;
    if (got.size() != exp.size()) begin failures++; $display("FAIL rmid_len got=%0d exp=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL rmid_char[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    ch_t got[$]; ch_t exp[$];
    int cyc, irl, sb, which; bit to, sup;
    logic [15:0] v;
    for (int n = 0; n < 24; n++) begin
      which = $urandom_range(1, 2);
      v     = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      sup   = 1'($urandom_range(0, 1));
      model(v, sup, which, exp);
      stream(which, v, sup, 2, -1, 1'b0, got, cyc, irl, sb, to);
      checks++; if (to) begin failures++; $display("FAIL rnd%0d_timeout v=%h got=timeout exp=done", n, v); end
      checks++; if (sb != 0) begin failures++; $display("FAIL rnd%0d_stall_stable got=%0d exp=0", n, sb); end
      checks++;
      if (got.size() != exp.size()) begin failures++; $display("FAIL rnd%0d_len v=%h sup=%b got=%0d exp=%0d", n, v, sup, got.size(), exp.size()); end
      else foreach (exp[i]) begin
        checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL rnd%0d_char[%0d] v=%h got=%h exp=%h", n, i, v, got[i], exp[i]); end
      end
      @(negedge clk);
      checks++; if (((which == 1) ? dn1 : dn2) !== 1'b0)
        begin failures++; $display("FAIL rnd%0d_done_width got=1 exp=0", n); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_suppress();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
